// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM port B burst master: write-enable codes,
// BRAM read latency and the controller state encoding.
package bram_pkg;

  localparam logic [3:0] BRAM_WE_WRITE = 4'b0111;
  localparam logic [3:0] BRAM_WE_NONE  = 4'b0000;
  localparam int         BRAM_RD_LAT   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2,
    WR       = 2'd3
  } bram_state_t;

endpackage

// File: rtl/bram_rd_fifo.sv
// Show-ahead read-return FIFO: the head entry is visible on 'head' while the
// FIFO is non-empty (zero otherwise); 'count' reports occupancy.
module bram_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;

  // Storage array; entries are only visible through the count, so no reset
  always_ff @(posedge CLK) begin
    if (push) mem[wptr_q] <= push_data;
  end

  // Pointer and occupancy tracking, flushed by reset
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = (cnt_q == '0) ? '0 : mem[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/bram_burst_master.sv
// Burst initiator for a 32-bit BRAM port B with fixed 2-cycle read latency.
// Read bursts return data on a valid/ready stream through a small buffer;
// write bursts forward a valid/ready stream straight into the BRAM.
// Optional build macro BRAM_BYTE_ADDR_EN: drive addrb as a byte address
// (word address << 2) for byte-addressed BRAM controllers.
module bram_burst_master
  import bram_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dinb,
  input  logic [DATA_W-1:0] doutb,
  output logic              enb,
  output logic [3:0]        web
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  bram_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              done_q, done_d;
  logic              vld_p0, vld_p1, last_p0, last_p1;
  logic              issue, wr_hs, cmd_hs, rd_hs, room;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [DATA_W:0]   fifo_head;

  function automatic logic [ADDR_W-1:0] bram_addr(input logic [ADDR_W-1:0] word_addr);
`ifdef BRAM_BYTE_ADDR_EN
    return word_addr << 2;
`else
    return word_addr;
`endif
  endfunction

  // Issue only when the beat is guaranteed a buffer slot on return
  assign room   = (SUM_W'(fifo_cnt) + SUM_W'(vld_p0) + SUM_W'(vld_p1)) < SUM_W'(FIFO_DEPTH);
  assign cmd_hs = cmd_valid && cmd_ready;
  assign rd_hs  = rd_valid && rd_ready;

  // Next-state decode and BRAM/handshake outputs
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    wr_hs     = 1'b0;
    cmd_ready = (state_q == IDLE) && RSTN;
    wr_ready  = (state_q == WR);
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = cmd_write ? WR : RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (room) begin
          issue = 1'b1;
          if (rem_q == LEN_W'(1)) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (!vld_p0 && !vld_p1 && fifo_cnt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      WR: begin
        if (wr_valid) begin
          wr_hs = 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    enb   = (state_q == RD_ISSUE) || (state_q == RD_DRAIN) || wr_hs;
    addrb = enb ? bram_addr(addr_q) : '0;
    dinb  = wr_hs ? wr_data : '0;
    web   = wr_hs ? BRAM_WE_WRITE : BRAM_WE_NONE;
  end

  // Control state: FSM, done pulse and in-flight issue flags
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      vld_p0  <= issue;
      vld_p1  <= vld_p0;
    end
  end

  // Burst address/length bookkeeping and last-beat tag following the flags
  always_ff @(posedge CLK) begin
    if (cmd_hs) begin
      addr_q <= cmd_addr;
      rem_q  <= cmd_len;
    end else if (issue || wr_hs) begin
      addr_q <= addr_q + ADDR_W'(1);
      rem_q  <= rem_q - LEN_W'(1);
    end
    // stage p0: beat issued to BRAM; stage p1: BRAM output registered
    last_p0 <= issue && (rem_q == LEN_W'(1));
    last_p1 <= last_p0;
  end

  bram_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .push      (vld_p1),
    .push_data ({last_p1, doutb}),
    .pop       (rd_hs),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  assign rd_valid = (fifo_cnt != '0);
  assign rd_data  = fifo_head[DATA_W-1:0];
  assign rd_last  = fifo_head[DATA_W];
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bram_burst_master.sv
// Directed bench for bram_burst_master with a BRAM port B model (2-cycle
// read latency) and a read-data scoreboard.
module tb_bram_burst_master;
  logic        CLK = 1'b0;
  logic        RSTN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done, busy;
  logic [31:0] addrb, dinb, doutb;
  logic        enb;
  logic [3:0]  web;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0, enb_cnt = 0, web_cnt = 0;
  logic [32:0] sb [$];

  logic [31:0] tbl [16] = '{32'd15, 32'd20, 32'd42, 32'd65, 32'd3, 32'd99, 32'd120, 32'd8,
                            32'd71, 32'd5, 32'd300, 32'd1234, 32'd16, 32'd43, 32'd11, 32'd7};

  always #5 CLK = ~CLK;

  bram_burst_master #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(8), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .busy(busy),
    .addrb(addrb), .dinb(dinb), .doutb(doutb), .enb(enb), .web(web)
  );

  function automatic logic [9:0] bidx(input logic [31:0] a);
`ifdef BRAM_BYTE_ADDR_EN
    return a[11:2];
`else
    return a[9:0];
`endif
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] w);
`ifdef BRAM_BYTE_ADDR_EN
    return {w[29:0], 2'b00};
`else
    return w;
`endif
  endfunction

  // BRAM port B model: write on web code, 2-stage read pipeline gated by enb
  logic [31:0] bram [1024];
  logic [31:0] s1, s2;
  assign doutb = s2;
  initial begin
    for (int i = 0; i < 1024; i++) bram[i] <= 32'(i * 7);
    for (int i = 0; i < 16; i++) bram[i + 1] <= tbl[i];
    bram[49]   <= 32'd777;
    bram[1023] <= 32'h1111;
    bram[0]    <= 32'h2222;
  end
  always @(posedge CLK) begin
    if (web == 4'b0111) bram[bidx(addrb)] <= dinb;
    if (enb) begin
      s1 <= bram[bidx(addrb)];
      s2 <= s1;
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic last);
    sb.push_back({last, d});
  endtask

  // Output monitor: scoreboard pops, done/web/enb bookkeeping
  always @(negedge CLK) begin
    if (RSTN === 1'b1) begin
      if (enb) enb_cnt++;
      if (web != 4'b0000) begin
        web_cnt++;
        check("web_code", web, 4'b0111);
        check("web_on_handshake", wr_valid && wr_ready, 1'b1);
      end
      if (done) begin
        done_cnt++;
        check("busy_with_done", busy, 1'b0);
      end
      if (rd_valid && rd_ready) begin
        check("rd_beat_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) check("rd_beat", {rd_last, rd_data}, sb.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string p);
    check({p, "_cmd_ready"}, cmd_ready, 1'b0);
    check({p, "_wr_ready"}, wr_ready, 1'b0);
    check({p, "_rd_valid"}, rd_valid, 1'b0);
    check({p, "_rd_data"}, rd_data, 32'd0);
    check({p, "_rd_last"}, rd_last, 1'b0);
    check({p, "_done"}, done, 1'b0);
    check({p, "_busy"}, busy, 1'b0);
    check({p, "_addrb"}, addrb, 32'd0);
    check({p, "_dinb"}, dinb, 32'd0);
    check({p, "_enb"}, enb, 1'b0);
    check({p, "_web"}, web, 4'b0000);
  endtask

  task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [7:0] l);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("idle_within_budget", n < budget, 1'b1);
    @(posedge CLK); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, e0, w0;
    RSTN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    @(posedge CLK); #1 RSTN = 1'b1;
    @(negedge CLK);
    check("cmd_ready_after_reset", cmd_ready, 1'b1);
    @(posedge CLK); #1;

    // Read burst addr 1, len 4, full rate
    rd_ready = 1'b1; d0 = done_cnt;
    for (int i = 0; i < 4; i++) push_exp(tbl[i], i == 3);
    issue_cmd(1'b0, 32'd1, 8'd4);
    @(negedge CLK);
    check("t1_busy", busy, 1'b1);
    check("t1_enb", enb, 1'b1);
    check("t1_addrb", addrb, exp_addr(32'd1));
    check("t1_rd_valid_e0", rd_valid, 1'b0);
    @(negedge CLK); check("t1_rd_valid_e1", rd_valid, 1'b0);
    @(negedge CLK); check("t1_rd_valid_e2", rd_valid, 1'b0);
    @(negedge CLK); check("t1_rd_valid_e3", rd_valid, 1'b1);
    check("t1_first_data", rd_data, 32'd15);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); check("t1_back_to_back", rd_valid, 1'b1);
    end
    @(posedge CLK); #1;
    wait_idle(50);
    check("t1_done_pulses", done_cnt - d0, 1);

    // 16-beat read with a backpressure window
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) push_exp(tbl[i], i == 15);
    issue_cmd(1'b0, 32'd1, 8'd16);
    repeat (3) @(posedge CLK);
    #1 rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("t2_enb_stall", enb, 1'b1);
      check("t2_busy_stall", busy, 1'b1);
    end
    @(posedge CLK); #1 rd_ready = 1'b1;
    wait_idle(200);
    check("t2_done_pulses", done_cnt - d0, 1);

    // Write burst addr 33, len 2 with a 2-cycle gap
    d0 = done_cnt; w0 = web_cnt;
    issue_cmd(1'b1, 32'd33, 8'd2);
    wr_valid = 1'b1; wr_data = 32'hAA;
    @(negedge CLK);
    check("t3_wr_ready", wr_ready, 1'b1);
    check("t3_web0", web, 4'b0111);
    check("t3_addrb0", addrb, exp_addr(32'd33));
    check("t3_dinb0", dinb, 32'hAA);
    @(posedge CLK); #1 wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("t3_web_gap", web, 4'b0000);
      check("t3_wr_ready_gap", wr_ready, 1'b1);
      @(posedge CLK); #1;
    end
    wr_valid = 1'b1; wr_data = 32'hBB;
    @(negedge CLK);
    check("t3_web1", web, 4'b0111);
    check("t3_addrb1", addrb, exp_addr(32'd34));
    check("t3_dinb1", dinb, 32'hBB);
    @(posedge CLK); #1 wr_valid = 1'b0; wr_data = '0;
    @(negedge CLK);
    check("t3_done", done, 1'b1);
    check("t3_busy_drop", busy, 1'b0);
    @(posedge CLK); #1;
    check("t3_web_cycles", web_cnt - w0, 2);
    check("t3_done_pulses", done_cnt - d0, 1);
    push_exp(32'hAA, 1'b0);
    push_exp(32'hBB, 1'b1);
    issue_cmd(1'b0, 32'd33, 8'd2);
    wait_idle(50);

    // Empty burst
    e0 = enb_cnt; w0 = web_cnt;
    issue_cmd(1'b0, 32'd5, 8'd0);
    @(negedge CLK);
    check("t4_done", done, 1'b1);
    check("t4_busy", busy, 1'b0);
    @(negedge CLK);
    check("t4_done_single", done, 1'b0);
    @(posedge CLK); #1;
    check("t4_no_enb", enb_cnt - e0, 0);
    check("t4_no_web", web_cnt - w0, 0);

    // Reset during the third beat of a 16-beat read
    rd_ready = 1'b0; d0 = done_cnt;
    issue_cmd(1'b0, 32'd1, 8'd16);
    @(posedge CLK); #1 RSTN = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check_all_zero("midreset");
    @(posedge CLK); #1 RSTN = 1'b1; rd_ready = 1'b1;
    @(negedge CLK);
    check("t5_rd_valid_flushed", rd_valid, 1'b0);
    @(posedge CLK); #1;
    push_exp(32'd777, 1'b1);
    issue_cmd(1'b0, 32'd49, 8'd1);
    wait_idle(50);
    check("t5_done_pulses", done_cnt - d0, 1);

    // Address wrap at the top of the address space
    push_exp(32'h1111, 1'b0);
    push_exp(32'h2222, 1'b1);
    issue_cmd(1'b0, 32'hFFFF_FFFF, 8'd2);
    @(negedge CLK);
    check("t6_addrb_top", addrb, exp_addr(32'hFFFF_FFFF));
    @(negedge CLK);
    check("t6_addrb_wrap", addrb, exp_addr(32'd0));
    @(posedge CLK); #1;
    wait_idle(50);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_burst_master.md
# bram_burst_master

Initiator for the 32-bit BRAM port B interface (addrb/dinb/doutb/enb/web). It accepts burst commands, drives sequential word accesses into a BRAM that has a fixed 2-cycle read latency, and returns read data on a valid/ready stream with backpressure. It also writes a valid/ready input stream into the BRAM. It sits between the SIMD datapath/controller and the matrix data BRAM, loading operand matrices and storing result matrices.

## Interface
- ADDR_W, 32, BRAM address width
- DATA_W, 32, word width
- LEN_W, 8, burst length field width (words)
- FIFO_DEPTH, 4, read return buffer depth; minimum 3
- CLK  in  1  clock, all logic on rising edge
- RSTN  in  1  reset; **synchronous, active-low**
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start word address
- cmd_len  in  LEN_W  number of words; 0 = empty burst
- wr_valid / wr_ready  in / out  1  write data handshake
- wr_data  in  DATA_W  write word
- rd_valid / rd_ready  out / in  1  read data handshake
- rd_data  out  DATA_W  read word
- rd_last  out  1  marks final beat of a read burst
- done  out  1  one-cycle pulse at burst completion
- busy  out  1  high when state is not IDLE
- addrb  out  ADDR_W  BRAM address
- dinb  out  DATA_W  BRAM write data
- doutb  in  DATA_W  BRAM read data
- enb  out  1  BRAM enable
- web  out  4  BRAM write enable

## Operation
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr/len/dir. len=0 goes to IDLE and pulses done next cycle. Otherwise go to RD_ISSUE or WR.
  - RD_ISSUE: drive addrb=current addr. A beat is issued when free FIFO slots exceed the in-flight count. Each issue increments addr and decrements the remaining count. When the last beat is issued, go to RD_DRAIN.
  - RD_DRAIN: wait until in-flight is 0, the FIFO is empty, and the last beat has been handshaken. Then pulse done and go to IDLE.
  - WR: wr_ready=1. On each wr_valid&wr_ready:
    - dinb=wr_data, web=4'b0111; this is the write code the BRAM decodes, and all other values are ignored.
    - addrb=current addr, then increment.
    - After the last beat, pulse done and go to IDLE.
- web=4'b0000 in every cycle that is not a write handshake. The BRAM evaluates web every cycle, independent of enb.
- enb=1 throughout RD_ISSUE and RD_DRAIN. The BRAM read pipeline and its output gate both depend on enb, so it must stay high until all in-flight data has been captured.
- Issue tracking:
  - A 2-deep shift register of issue flags tracks in-flight beats.
  - doutb is pushed into the FIFO only in cycles where the flag from 2 cycles earlier is set.
  - Stalled cycles that hold addrb produce data that is discarded.
- Address increment wraps modulo 2^ADDR_W.
- rd_last is set on the FIFO entry for beat cmd_len-1.
- Commands are never accepted while busy.

## Timing
- Reset values:
  - cmd_ready=0 during reset, 1 in the first cycle after reset.
  - All other outputs 0: wr_ready, rd_valid, rd_data, rd_last, done, busy, addrb, dinb, enb, web.
  - FIFO flushed, in-flight flags cleared.
- Read latency, with the command accepted at edge E:
  - addrb is valid after E; the BRAM samples it at E+1.
  - doutb is valid after E+2 and captured at E+3.
  - rd_valid rises after E+3.
- Sustained throughput is 1 word/cycle when rd_ready is held high.
- Write: first wr_ready is the cycle after acceptance. Each handshake cycle drives addrb/dinb/web combinationally from registered state plus wr_data.
- done: registered, high for exactly 1 cycle, and busy drops in that same cycle.
- RSTN low mid-burst: next edge returns to IDLE and discards all in-flight/buffered data; no done pulse.

## Configuration
- BRAM_BYTE_ADDR_EN:
  - Defined: addrb = word address << 2 and increments by 4, for byte-addressed BRAM controllers. cmd_addr is still a word address.
  - Undefined: addrb = word address, increment by 1. This is the default and matches the current word-indexed BRAM.

## Structure
- Package bram_pkg:
  - BRAM_WE_WRITE = 4'b0111, BRAM_WE_NONE = 4'b0000
  - BRAM_RD_LAT = 2
  - state enum typedef (IDLE, RD_ISSUE, RD_DRAIN, WR)
- Sub-module bram_rd_fifo: synchronous show-ahead FIFO (FIFO_DEPTH × (DATA_W+1)) carrying data plus the last flag, with a count output.

## Test plan
- Read burst, cmd_addr=1, len=4, rd_ready=1 → rd_data 15,20,42,65 on consecutive cycles, rd_valid first high after E+3, rd_last with 65, one done pulse.
- 16-beat read from 1, rd_ready low for cycles 4–8 → full sequence 15…7, no loss or duplication, enb held high, FIFO never overflows.
- Write cmd_addr=33, len=2, wr_data 0xAA then 0xBB with a 2-cycle gap → web=4'b0111 only on the 2 handshake cycles. A following read of addr 33, len 2 returns 0xAA, 0xBB.
- len=0 command → done pulse next cycle, enb and web never asserted.
- RSTN low during the third beat of a 16-beat read → all outputs 0 next cycle. A fresh read from 49, len 1 returns 777.
- With BRAM_BYTE_ADDR_EN defined, cmd_addr=2, len=2 → addrb sequence 8, 12.
